// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix pipeline stages: element type, default
// geometry and the row-major element index used by the packed layout.
package matrix_pkg;

   localparam int MAT_H           = 8;
   localparam int MAT_W           = 8;
   localparam int MAT_DATA_WIDTH  = 16;
   localparam int MAT_FRACT_WIDTH = 8;

   typedef logic signed [MAT_DATA_WIDTH-1:0] ELEM_T;

   function automatic int idx(input int i, input int j);
      return i * MAT_W + j;
   endfunction

endpackage

// File: rtl/matrix_bank.sv
// One packed matrix buffer with per-element write and a full flag that
// marks the buffer as holding a complete matrix for the downstream stage.
module matrix_bank #(
   parameter int N          = 64,
   parameter int DATA_WIDTH = 16,
   localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [IW-1:0]           idx_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    set_full_i,
   input  logic                    clr_i,
   output logic [N*DATA_WIDTH-1:0] data_o,
   output logic                    full_o
);

   logic [N*DATA_WIDTH-1:0] mem_q;
   logic                    full_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '0;
         full_q <= 1'b0;
      end else begin
         if (we_i) begin
            mem_q[int'(idx_i)*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
         end
         // Fill and drain never target the same bank in one cycle.
         if (set_full_i) begin
            full_q <= 1'b1;
         end else if (clr_i) begin
            full_q <= 1'b0;
         end
      end
   end

   assign data_o = mem_q;
   assign full_o = full_q;

endmodule

// File: rtl/matrix_stream_packer.sv
// Packs a row-major element stream into H*W matrices through two ping-pong
// banks; the upstream may fill one bank while the other waits downstream.
module matrix_stream_packer
   import matrix_pkg::*;
#(
   parameter int H           = MAT_H,
   parameter int W           = MAT_W,
   parameter int DATA_WIDTH  = MAT_DATA_WIDTH,
   parameter int FRACT_WIDTH = MAT_FRACT_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_WIDTH-1:0]     s_data,
   input  logic                      s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [H*W*DATA_WIDTH-1:0] m_data,
   output logic                      frame_err,
   output logic [1:0]                banks_full
);

   localparam int N  = H * W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (FRACT_WIDTH > DATA_WIDTH) begin : g_fract_chk
      $error("FRACT_WIDTH must not exceed DATA_WIDTH");
   end

   logic [CW-1:0]         count_q, count_d;
   logic                  wr_sel_q, wr_sel_d;
   logic                  rd_sel_q, rd_sel_d;
   logic                  frame_err_q, frame_err_d;
   logic                  run_q;
   logic [1:0]            full;
   logic [N*DATA_WIDTH-1:0] bank_data [2];
   logic                  xfer, consume, last_elem;

   // Handshake: a transfer happens on an edge where valid & ready are both high;
   // ready never depends on valid on the same side.
   assign s_ready    = run_q & ~full[wr_sel_q];
   assign m_valid    = full[rd_sel_q];
   assign m_data     = bank_data[rd_sel_q];
   assign banks_full = full;
   assign frame_err  = frame_err_q;

   assign xfer      = s_valid & s_ready;
   assign consume   = m_valid & m_ready;
   assign last_elem = (count_q == CW'(N - 1));

   always_comb begin
      count_d     = count_q;
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;
      frame_err_d = 1'b0;
      if (xfer) begin
         if (last_elem) begin
            count_d     = '0;
            wr_sel_d    = ~wr_sel_q;
            frame_err_d = ~s_last;
         end else if (s_last) begin
            // Short frame: drop the partial matrix and reuse the same bank.
            count_d     = '0;
            frame_err_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
      if (consume) begin
         rd_sel_d = ~rd_sel_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         frame_err_q <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         count_q     <= count_d;
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         frame_err_q <= frame_err_d;
         run_q       <= 1'b1;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      matrix_bank #(
         .N          (N),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .clk        (clk),
         .rst        (rst),
         .we_i       (xfer & (wr_sel_q == 1'(b))),
         .idx_i      (count_q),
         .wdata_i    (s_data),
         .set_full_i (xfer & last_elem & (wr_sel_q == 1'(b))),
         .clr_i      (consume & (rd_sel_q == 1'(b))),
         .data_o     (bank_data[b]),
         .full_o     (full[b])
      );
   end

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Directed bench: a 2x2 instance for framing/backpressure/reset cases and a
// default 8x8 instance for sustained single-element-per-cycle streaming.
module tb_matrix_stream_packer;
   import matrix_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // 2x2 instance
   logic        sm_s_valid, sm_s_ready, sm_s_last, sm_m_valid, sm_m_ready, sm_frame_err;
   logic [15:0] sm_s_data;
   logic [63:0] sm_m_data;
   logic [1:0]  sm_banks_full;

   // 8x8 instance
   logic          lg_s_valid, lg_s_ready, lg_s_last, lg_m_valid, lg_m_ready, lg_frame_err;
   logic [15:0]   lg_s_data;
   logic [1023:0] lg_m_data;
   logic [1:0]    lg_banks_full;

   logic [1023:0] exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   matrix_stream_packer #(.H(2), .W(2), .DATA_WIDTH(16), .FRACT_WIDTH(8)) dut_sm (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (sm_s_valid),
      .s_ready    (sm_s_ready),
      .s_data     (sm_s_data),
      .s_last     (sm_s_last),
      .m_valid    (sm_m_valid),
      .m_ready    (sm_m_ready),
      .m_data     (sm_m_data),
      .frame_err  (sm_frame_err),
      .banks_full (sm_banks_full)
   );

   matrix_stream_packer dut_lg (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (lg_s_valid),
      .s_ready    (lg_s_ready),
      .s_data     (lg_s_data),
      .s_last     (lg_s_last),
      .m_valid    (lg_m_valid),
      .m_ready    (lg_m_ready),
      .m_data     (lg_m_data),
      .frame_err  (lg_frame_err),
      .banks_full (lg_banks_full)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one element and holds it until the edge that transfers it.
   task automatic send_sm(input logic [15:0] d, input logic last);
      logic rdy;
      bit   done;
      done       = 1'b0;
      sm_s_valid = 1'b1;
      sm_s_data  = d;
      sm_s_last  = last;
      for (int t = 0; t < 20 && !done; t++) begin
         rdy = sm_s_ready;
         tick();
         done = rdy;
      end
      sm_s_valid = 1'b0;
      sm_s_last  = 1'b0;
      sm_s_data  = 16'h0;
      chk("sm_send_accepted", 128'(done), 128'(1));
   endtask

   task automatic send_sm_matrix(input logic [15:0] base, input logic with_last);
      for (int k = 0; k < 4; k++) begin
         send_sm(base + 16'(k), with_last && (k == 3));
      end
   endtask

   initial begin
      logic [1023:0] cur;
      logic [1023:0] exp_m;
      ELEM_T         d;
      int            m, k;
      bit            exp_mv;

      sm_s_valid = 1'b0; sm_s_data = '0; sm_s_last = 1'b0; sm_m_ready = 1'b0;
      lg_s_valid = 1'b0; lg_s_data = '0; lg_s_last = 1'b0; lg_m_ready = 1'b0;
      cur = '0;

      // reset state
      #3;
      chk("rst_m_valid",    128'(sm_m_valid),    128'(0));
      chk("rst_s_ready",    128'(sm_s_ready),    128'(0));
      chk("rst_banks_full", 128'(sm_banks_full), 128'(0));
      chk("rst_m_data",     128'(sm_m_data),     128'(0));
      chk("rst_frame_err",  128'(sm_frame_err),  128'(0));
      chk("rst_lg_s_ready", 128'(lg_s_ready),    128'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();

      // basic pack
      sm_m_ready = 1'b1;
      send_sm(16'h0001, 1'b0);
      send_sm(16'h0002, 1'b0);
      send_sm(16'hFFFF, 1'b0);
      send_sm(16'h8000, 1'b1);
      chk("basic_m_valid",   128'(sm_m_valid),   128'(1));
      chk("basic_m_data",    128'(sm_m_data),    128'(64'h8000_FFFF_0002_0001));
      chk("basic_frame_err", 128'(sm_frame_err), 128'(0));
      tick();
      chk("basic_pulse_len", 128'(sm_m_valid),    128'(0));
      chk("basic_banks_clr", 128'(sm_banks_full), 128'(0));

      // backpressure: A -> bank1, B -> bank0, C -> bank1
      sm_m_ready = 1'b0;
      send_sm_matrix(16'hA000, 1'b1);
      chk("bp_s_ready_after4", 128'(sm_s_ready), 128'(1));
      send_sm_matrix(16'hB000, 1'b1);
      chk("bp_banks_full", 128'(sm_banks_full), 128'(2'b11));
      chk("bp_s_ready_low", 128'(sm_s_ready), 128'(0));
      chk("bp_m_data_a", 128'(sm_m_data), 128'(64'hA003_A002_A001_A000));
      sm_s_valid = 1'b1;
      sm_s_data  = 16'hC000;
      sm_s_last  = 1'b0;
      for (int t = 0; t < 2; t++) begin
         chk("bp_stall_ready", 128'(sm_s_ready), 128'(0));
         tick();
      end
      sm_m_ready = 1'b1;
      chk("bp_exit_valid", 128'(sm_m_valid), 128'(1));
      chk("bp_exit_data",  128'(sm_m_data),  128'(64'hA003_A002_A001_A000));
      tick();
      sm_m_ready = 1'b0;
      chk("bp_ready_back", 128'(sm_s_ready),    128'(1));
      chk("bp_banks_one",  128'(sm_banks_full), 128'(2'b01));
      chk("bp_m_data_b",   128'(sm_m_data),     128'(64'hB003_B002_B001_B000));
      tick();
      sm_s_valid = 1'b0;
      send_sm(16'hC001, 1'b0);
      send_sm(16'hC002, 1'b0);
      send_sm(16'hC003, 1'b1);
      chk("bp_banks_full2", 128'(sm_banks_full), 128'(2'b11));
      chk("bp_b_held",      128'(sm_m_data),     128'(64'hB003_B002_B001_B000));
      sm_m_ready = 1'b1;
      tick();
      chk("bp_c_valid", 128'(sm_m_valid), 128'(1));
      chk("bp_c_data",  128'(sm_m_data),  128'(64'hC003_C002_C001_C000));
      tick();
      chk("bp_drained", 128'(sm_banks_full), 128'(0));

      // sustained throughput on 8x8
      lg_m_ready = 1'b1;
      for (int c = 0; c <= 192; c++) begin
         exp_mv = (c >= 64) && (c % 64 == 0);
         chk("lg_m_valid", 128'(lg_m_valid), 128'(exp_mv));
         if (lg_m_valid) begin
            if (exp_q.size() == 0) begin
               chk("lg_unexpected_matrix", 128'(1), 128'(0));
            end else begin
               exp_m = exp_q.pop_front();
               for (int r = 0; r < 8; r++) begin
                  chk($sformatf("lg_row%0d", r), lg_m_data[r*128 +: 128], exp_m[r*128 +: 128]);
               end
            end
         end
         if (c < 192) begin
            chk("lg_s_ready", 128'(lg_s_ready), 128'(1));
            m = c / 64;
            k = c % 64;
            d = ELEM_T'((m * 64 + k) * 97 + 32'h8123);
            cur[idx(k / 8, k % 8)*16 +: 16] = d;
            lg_s_valid = 1'b1;
            lg_s_data  = d;
            lg_s_last  = (k == 63);
            if (k == 63) exp_q.push_back(cur);
         end else begin
            lg_s_valid = 1'b0;
            lg_s_last  = 1'b0;
         end
         tick();
      end
      chk("lg_queue_empty", 128'(exp_q.size()), 128'(0));

      // short frame
      sm_m_ready = 1'b1;
      send_sm(16'h1111, 1'b0);
      send_sm(16'h2222, 1'b1);
      chk("short_frame_err", 128'(sm_frame_err),  128'(1));
      chk("short_no_valid",  128'(sm_m_valid),    128'(0));
      chk("short_banks",     128'(sm_banks_full), 128'(0));
      tick();
      chk("short_err_len", 128'(sm_frame_err), 128'(0));
      send_sm_matrix(16'h3000, 1'b1);
      chk("short_next_valid", 128'(sm_m_valid),   128'(1));
      chk("short_next_data",  128'(sm_m_data),    128'(64'h3003_3002_3001_3000));
      chk("short_next_err",   128'(sm_frame_err), 128'(0));
      tick();

      // missing s_last
      send_sm_matrix(16'h4000, 1'b0);
      chk("nolast_valid", 128'(sm_m_valid),   128'(1));
      chk("nolast_err",   128'(sm_frame_err), 128'(1));
      chk("nolast_data",  128'(sm_m_data),    128'(64'h4003_4002_4001_4000));
      tick();
      chk("nolast_err_len", 128'(sm_frame_err), 128'(0));
      chk("nolast_drained", 128'(sm_m_valid),   128'(0));

      // async reset mid-operation
      sm_m_ready = 1'b0;
      send_sm_matrix(16'h5000, 1'b1);
      send_sm(16'h6000, 1'b0);
      send_sm(16'h6001, 1'b0);
      chk("ar_held_valid", 128'(sm_m_valid),    128'(1));
      chk("ar_banks",      128'(sm_banks_full), 128'(2'b01));
      #2;
      rst = 1'b1;
      #1;
      chk("ar_m_valid", 128'(sm_m_valid),    128'(0));
      chk("ar_s_ready", 128'(sm_s_ready),    128'(0));
      chk("ar_banks0",  128'(sm_banks_full), 128'(0));
      chk("ar_m_data",  128'(sm_m_data),     128'(0));
      @(negedge clk);
      rst = 1'b0;
      tick();
      sm_m_ready = 1'b1;
      send_sm_matrix(16'h7000, 1'b1);
      chk("ar_fresh_valid", 128'(sm_m_valid),    128'(1));
      chk("ar_fresh_data",  128'(sm_m_data),     128'(64'h7003_7002_7001_7000));
      chk("ar_fresh_bank",  128'(sm_banks_full), 128'(2'b01));
      tick();
      chk("ar_fresh_drained", 128'(sm_m_valid), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
